// File: rtl/manchester_pkg.sv
// Shared types for the Manchester byte framer: FSM state encoding and default sync byte.
package manchester_pkg;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_LEN     = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'hD5;

endpackage

// File: rtl/manchester_byte_framer_byte_fifo.sv
// Small synchronous FIFO of {last, data} entries; a pop in the same cycle frees a slot for a push when full.
module byte_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       push,
    input  logic [8:0] push_entry,
    input  logic       pop,
    output logic [8:0] head,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [8:0]  mem [FIFO_DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head is forced to zero when empty so tdata/tlast read 0 whenever tvalid is low.
    assign head = empty ? 9'd0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= 9'd0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_entry;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/manchester_byte_framer.sv
// Frames the decoded Manchester bit stream: sync hunt, length byte, MSB-first payload
// bytes out through a FIFO on AXI4-Stream, with stall-timeout and overflow aborts.
module manchester_byte_framer
    import manchester_pkg::*;
#(
    parameter logic [7:0] SYNC_WORD      = SYNC_DEFAULT,
    parameter int         FIFO_DEPTH     = 4,
    parameter int         TIMEOUT_CYCLES = 64
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic [1:0] decoded_bits,
    input  logic [1:0] num_decoded_bits,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       m_axis_tlast,
    output logic       in_frame,
    output logic       sync_found,
    output logic       err_timeout,
    output logic       err_overflow
);
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(TIMEOUT_CYCLES);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);
    localparam logic [IW-1:0] IDLE_ONE  = 1;

    state_t        state_q, state_n;
    logic [7:0]    window_q, window_n;
    logic [2:0]    bit_cnt_q, bit_cnt_n;
    logic [7:0]    remaining_q, remaining_n;
    logic [IW-1:0] idle_q, idle_n;
    logic          sync_q, timeout_q, overflow_q, in_frame_q;

    logic          sync_det, timeout_det, overflow_det;
    logic          has_bits, bit_ok, bit_val, last_byte;
    logic          push, pop;
    logic [8:0]    push_entry, head;
    logic          fifo_full, fifo_empty;

    byte_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = head[7:0];
    assign m_axis_tlast  = head[8];
    assign pop           = m_axis_tvalid && m_axis_tready;

    assign in_frame     = in_frame_q;
    assign sync_found   = sync_q;
    assign err_timeout  = timeout_q;
    assign err_overflow = overflow_q;

    always_comb begin
        state_n      = state_q;
        window_n     = window_q;
        bit_cnt_n    = bit_cnt_q;
        remaining_n  = remaining_q;
        idle_n       = idle_q;
        sync_det     = 1'b0;
        timeout_det  = 1'b0;
        overflow_det = 1'b0;
        push         = 1'b0;
        push_entry   = 9'd0;
        bit_ok       = 1'b0;
        bit_val      = 1'b0;
        last_byte    = 1'b0;
        has_bits     = (num_decoded_bits == 2'd1) || (num_decoded_bits == 2'd2);

        if (!has_bits && state_q != ST_HUNT && idle_q == IDLE_LAST) begin
            timeout_det = 1'b1;
            state_n     = ST_HUNT;
            window_n    = 8'd0;
            bit_cnt_n   = 3'd0;
        end

        // Slot 0 carries the older bit of a pair; a single bit always rides in slot 1.
        for (int k = 0; k < 2; k++) begin
            bit_ok  = (num_decoded_bits == 2'd2) || (num_decoded_bits == 2'd1 && k == 1);
            bit_val = (k == 0) ? decoded_bits[1] : decoded_bits[0];
            if (bit_ok) begin
                window_n = {window_n[6:0], bit_val};
                case (state_n)
                    ST_HUNT: begin
                        if (window_n == SYNC_WORD) begin
                            state_n   = ST_LEN;
                            bit_cnt_n = 3'd0;
                            sync_det  = 1'b1;
                        end
                    end
                    ST_LEN: begin
                        if (bit_cnt_n == 3'd7) begin
                            bit_cnt_n = 3'd0;
                            if (window_n == 8'd0) begin
                                state_n  = ST_HUNT;
                                window_n = 8'd0;
                            end else begin
                                remaining_n = window_n;
                                state_n     = ST_PAYLOAD;
                            end
                        end else begin
                            bit_cnt_n = bit_cnt_n + 3'd1;
                        end
                    end
                    ST_PAYLOAD: begin
                        if (bit_cnt_n == 3'd7) begin
                            bit_cnt_n = 3'd0;
                            if (fifo_full && !pop) begin
                                overflow_det = 1'b1;
                                state_n      = ST_HUNT;
                                window_n     = 8'd0;
                            end else begin
                                last_byte   = (remaining_n == 8'd1);
                                push        = 1'b1;
                                push_entry  = {last_byte, window_n};
                                remaining_n = remaining_n - 8'd1;
                                if (last_byte) begin
                                    state_n  = ST_HUNT;
                                    window_n = 8'd0;
                                end
                            end
                        end else begin
                            bit_cnt_n = bit_cnt_n + 3'd1;
                        end
                    end
                    default: begin
                        state_n   = ST_HUNT;
                        window_n  = 8'd0;
                        bit_cnt_n = 3'd0;
                    end
                endcase
            end
        end

        if (state_n == ST_HUNT || has_bits) begin
            idle_n = '0;
        end else if (idle_q != IDLE_MAX) begin
            idle_n = idle_q + IDLE_ONE;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_HUNT;
            window_q    <= 8'd0;
            bit_cnt_q   <= 3'd0;
            remaining_q <= 8'd0;
            idle_q      <= '0;
            sync_q      <= 1'b0;
            timeout_q   <= 1'b0;
            overflow_q  <= 1'b0;
            in_frame_q  <= 1'b0;
        end else begin
            state_q     <= state_n;
            window_q    <= window_n;
            bit_cnt_q   <= bit_cnt_n;
            remaining_q <= remaining_n;
            idle_q      <= idle_n;
            sync_q      <= sync_det;
            timeout_q   <= timeout_det;
            overflow_q  <= overflow_det;
            in_frame_q  <= (state_n != ST_HUNT);
        end
    end

endmodule

// File: tb/tb_manchester_byte_framer.sv
// Directed bench for manchester_byte_framer: single-bit and paired feeds, gapped input,
// stall timeout, FIFO overflow and mid-frame reset.
module tb_manchester_byte_framer;

    logic       aclk = 1'b0;
    logic       aresetn;
    logic [1:0] decoded_bits;
    logic [1:0] num_decoded_bits;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic       m_axis_tlast;
    logic       in_frame;
    logic       sync_found;
    logic       err_timeout;
    logic       err_overflow;

    int n_assert = 0;
    int n_fail   = 0;
    int sync_cnt = 0;
    int tmo_cnt  = 0;
    int ovf_cnt  = 0;
    int base;
    int sync_base;

    logic [7:0] rx_data[$];
    logic       rx_last[$];
    logic       bq[$];

    always #5 aclk = ~aclk;

    manchester_byte_framer dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .decoded_bits     (decoded_bits),
        .num_decoded_bits (num_decoded_bits),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .m_axis_tlast     (m_axis_tlast),
        .in_frame         (in_frame),
        .sync_found       (sync_found),
        .err_timeout      (err_timeout),
        .err_overflow     (err_overflow)
    );

    always @(posedge aclk) begin
        if (aresetn) begin
            if (m_axis_tvalid && m_axis_tready) begin
                rx_data.push_back(m_axis_tdata);
                rx_last.push_back(m_axis_tlast);
            end
            if (sync_found)   sync_cnt = sync_cnt + 1;
            if (err_timeout)  tmo_cnt  = tmo_cnt + 1;
            if (err_overflow) ovf_cnt  = ovf_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rx_at(input int idx);
        if (idx < rx_data.size()) return {23'd0, rx_last[idx], rx_data[idx]};
        return 32'hDEAD;
    endfunction

    task automatic drive_cycle(input logic [1:0] n, input logic [1:0] d);
        @(negedge aclk);
        num_decoded_bits = n;
        decoded_bits     = d;
        @(posedge aclk);
        #1;
        num_decoded_bits = 2'd0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) drive_cycle(2'd1, {1'b0, v[i]});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic q_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) bq.push_back(v[i]);
    endtask

    int   pat [8] = '{2, 0, 1, 3, 2, 1, 0, 2};
    int   pidx;
    int   k;
    logic b1, b0;

    initial begin
        aresetn          = 1'b0;
        decoded_bits     = 2'd0;
        num_decoded_bits = 2'd0;
        m_axis_tready    = 1'b1;
        idle(3);

        // Reset state
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_tlast", m_axis_tlast, 0);
        chk("rst_in_frame", in_frame, 0);
        chk("rst_sync", sync_found, 0);
        chk("rst_tmo", err_timeout, 0);
        chk("rst_ovf", err_overflow, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        idle(2);

        // Single-bit feed
        base = rx_data.size();
        send_byte(8'hD5);
        chk("t1_sync_pulse", sync_found, 1);
        chk("t1_in_frame", in_frame, 1);
        send_byte(8'h03);
        send_byte(8'hA1);
        chk("t1_latency_tvalid", m_axis_tvalid, 1);
        chk("t1_latency_tdata", m_axis_tdata, 8'hA1);
        send_byte(8'hB2);
        send_byte(8'hC3);
        idle(4);
        chk("t1_sync_cnt", sync_cnt, 1);
        chk("t1_nbytes", rx_data.size() - base, 3);
        chk("t1_b0", rx_at(base), {1'b0, 8'hA1});
        chk("t1_b1", rx_at(base + 1), {1'b0, 8'hB2});
        chk("t1_b2", rx_at(base + 2), {1'b1, 8'hC3});
        chk("t1_hunt", in_frame, 0);

        // Paired feed, sync completes on the older bit of a pair
        base = rx_data.size();
        sync_base = sync_cnt;
        bq.push_back(1'b0);
        q_byte(8'hD5); q_byte(8'h03); q_byte(8'hA1); q_byte(8'hB2); q_byte(8'hC3);
        while (bq.size() >= 2) begin
            b1 = bq.pop_front();
            b0 = bq.pop_front();
            drive_cycle(2'd2, {b1, b0});
        end
        if (bq.size() == 1) drive_cycle(2'd1, {1'b0, bq.pop_front()});
        idle(4);
        chk("t2_sync_cnt", sync_cnt - sync_base, 1);
        chk("t2_nbytes", rx_data.size() - base, 3);
        chk("t2_b0", rx_at(base), {1'b0, 8'hA1});
        chk("t2_b1", rx_at(base + 1), {1'b0, 8'hB2});
        chk("t2_b2", rx_at(base + 2), {1'b1, 8'hC3});

        // Gapped feed with partial-sync noise and illegal count-3 cycles
        base = rx_data.size();
        sync_base = sync_cnt;
        bq.push_back(1'b1); bq.push_back(1'b1); bq.push_back(1'b0);
        bq.push_back(1'b1); bq.push_back(1'b0); bq.push_back(1'b0); bq.push_back(1'b0);
        q_byte(8'hD5); q_byte(8'h02); q_byte(8'h5A); q_byte(8'h3C);
        pidx = 0;
        while (bq.size() > 0) begin
            k = pat[pidx % 8];
            pidx++;
            if (k == 0) drive_cycle(2'd0, 2'b00);
            else if (k == 3) drive_cycle(2'd3, 2'b11);
            else if (k == 1 || bq.size() == 1) drive_cycle(2'd1, {1'b0, bq.pop_front()});
            else begin
                b1 = bq.pop_front();
                b0 = bq.pop_front();
                drive_cycle(2'd2, {b1, b0});
            end
        end
        idle(4);
        chk("t3_sync_cnt", sync_cnt - sync_base, 1);
        chk("t3_nbytes", rx_data.size() - base, 2);
        chk("t3_b0", rx_at(base), {1'b0, 8'h5A});
        chk("t3_b1", rx_at(base + 1), {1'b1, 8'h3C});

        // Stall timeout after two of five payload bytes
        base = rx_data.size();
        send_byte(8'hD5); send_byte(8'h05); send_byte(8'h11); send_byte(8'h22);
        idle(63);
        chk("t4_no_tmo_early", err_timeout, 0);
        chk("t4_still_frame", in_frame, 1);
        idle(1);
        chk("t4_tmo_pulse", err_timeout, 1);
        chk("t4_hunt", in_frame, 0);
        idle(1);
        chk("t4_tmo_single", err_timeout, 0);
        chk("t4_tmo_cnt", tmo_cnt, 1);
        chk("t4_nbytes", rx_data.size() - base, 2);
        chk("t4_b0", rx_at(base), {1'b0, 8'h11});
        chk("t4_b1", rx_at(base + 1), {1'b0, 8'h22});
        base = rx_data.size();
        send_byte(8'hD5); send_byte(8'h01); send_byte(8'h77);
        idle(3);
        chk("t4_next_nbytes", rx_data.size() - base, 1);
        chk("t4_next_b0", rx_at(base), {1'b1, 8'h77});

        // Overflow with sink stalled
        @(negedge aclk);
        m_axis_tready = 1'b0;
        base = rx_data.size();
        send_byte(8'hD5); send_byte(8'h06);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        chk("t5_no_ovf_yet", err_overflow, 0);
        send_byte(8'h05);
        chk("t5_ovf_pulse", err_overflow, 1);
        chk("t5_hunt", in_frame, 0);
        idle(3);
        chk("t5_hold_tvalid", m_axis_tvalid, 1);
        chk("t5_hold_tdata", m_axis_tdata, 8'h01);
        chk("t5_hold_tlast", m_axis_tlast, 0);
        chk("t5_ovf_cnt", ovf_cnt, 1);
        @(negedge aclk);
        m_axis_tready = 1'b1;
        idle(6);
        chk("t5_nbytes", rx_data.size() - base, 4);
        for (int i = 0; i < 4; i++) chk("t5_byte", rx_at(base + i), {1'b0, 8'(i + 1)});
        chk("t5_drained", m_axis_tvalid, 0);

        // Reset mid-payload
        @(negedge aclk);
        m_axis_tready = 1'b0;
        send_byte(8'hD5); send_byte(8'h04); send_byte(8'hAA);
        drive_cycle(2'd1, 2'b01); drive_cycle(2'd1, 2'b00);
        chk("t6_pre_tvalid", m_axis_tvalid, 1);
        @(negedge aclk);
        aresetn = 1'b0;
        #1;
        chk("t6_rst_tvalid", m_axis_tvalid, 0);
        chk("t6_rst_tdata", m_axis_tdata, 0);
        chk("t6_rst_in_frame", in_frame, 0);
        idle(2);
        @(negedge aclk);
        aresetn = 1'b1;
        m_axis_tready = 1'b1;
        base = rx_data.size();
        send_byte(8'hD5); send_byte(8'h01); send_byte(8'h99);
        idle(3);
        chk("t6_nbytes", rx_data.size() - base, 1);
        chk("t6_b0", rx_at(base), {1'b1, 8'h99});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/manchester_byte_framer.md
# manchester_byte_framer

Downstream of the Manchester decoder: consumes its 0–2 decoded bits per cycle, hunts for a sync byte, reads a length byte, then assembles that many payload bytes MSB-first. Bytes are delivered on an AXI4-Stream master through a small output FIFO, with `tlast` on the final byte of each frame. Also detects bit-stream stalls and output overflow, aborting the frame in either case.

## Interface
Parameters:
- `SYNC_WORD`, 8'hD5: frame sync byte.
- `FIFO_DEPTH`, 4: output FIFO entries; power of two, ≥ 2.
- `TIMEOUT_CYCLES`, 64: idle cycles without bits that abort an in-progress frame; ≥ 2.

Ports:
- `aclk`  in  1  clock; one clock domain.
- `aresetn`  in  1  reset; asynchronous, active-low.
- `decoded_bits`  in  2  decoded bits.
  - When count = 2, `[1]` is older and `[0]` is newer.
  - When count = 1, only `[0]` is valid.
- `num_decoded_bits`  in  2  valid bit count, 0..2; value 3 is illegal and the input is ignored.
- `m_axis_tdata`  out  8  payload byte.
- `m_axis_tvalid`  out  1  byte valid.
- `m_axis_tready`  in  1  sink ready.
- `m_axis_tlast`  out  1  last byte of frame.
- `in_frame`  out  1  high in LEN or PAYLOAD state.
- `sync_found`  out  1  one-cycle pulse on sync match.
- `err_timeout`  out  1  one-cycle pulse on stall abort.
- `err_overflow`  out  1  one-cycle pulse on FIFO-full abort.

## Operation
- Bits are processed serially in arrival order: `[1]` then `[0]` when count = 2.
- Each bit shifts into an 8-bit window, MSB-first (new bit enters at LSB).
- States:
  - **HUNT**: compare the window after *each* bit. On a match with `SYNC_WORD`, go to LEN and pulse `sync_found`. If the match occurred on the older bit of a pair, the newer bit becomes bit 7 of the length byte.
  - **LEN**: collect 8 bits into the length L.
    - L = 0: return to HUNT, no output.
    - Otherwise load remaining = L and go to PAYLOAD.
  - **PAYLOAD**: collect bytes, pushing {data, last = (remaining == 1)} into the FIFO and decrementing remaining. After the last byte, go to HUNT.
- Per-bit counter 0..7. A byte completes on the 8th bit, which may be either bit of a pair; a leftover newer bit starts the next byte. At most one byte completes per cycle.
- Entering HUNT from any state clears the window and bit counter. A leftover bit in the same cycle is shifted into the cleared window.
- **Timeout**:
  - An idle counter counts cycles with count = 0 while not in HUNT. It clears on any cycle with bits, and is held at 0 in HUNT.
  - On reaching `TIMEOUT_CYCLES`: pulse `err_timeout`, go to HUNT.
  - Bytes already queued are delivered. No `tlast` is generated for the aborted frame.
- **Overflow**: if a byte completes while the FIFO is full, drop it, pulse `err_overflow` and go to HUNT. Queued bytes still drain.
- **FIFO**:
  - Simultaneous push and pop when full is *not* treated as a push into a full FIFO: the pop frees the slot first.
  - Simultaneous push and pop when empty is legal; the byte appears the next cycle.
- Width rules:
  - remaining: 8 bits.
  - Idle counter: `$clog2(TIMEOUT_CYCLES+1)` bits, saturating.
  - FIFO pointers: `$clog2(FIFO_DEPTH)+1` bits, wrapping.

## Timing
- Reset (async assert, sync-safe deassert): state HUNT; window, counters and FIFO cleared. All outputs are 0: `tvalid`, `tlast`, `tdata`, `in_frame` and all pulses.
- Latency: a byte completing in cycle T gives `m_axis_tvalid` = 1 in T+1 when the FIFO is empty.
- Pulse timing:
  - `sync_found`: registered, high in T+1 for a match in T.
  - `err_timeout`, `err_overflow`: high in the cycle after detection.
- `in_frame`: registered from state.
- AXIS rules:
  - `tdata`/`tlast` are held stable while `tvalid` is high and `tready` is low.
  - A transfer occurs on `tvalid & tready`.
  - With `tready` held high, throughput is one byte per cycle.
- Reset mid-frame: the frame is discarded and the FIFO emptied immediately.

## Structure
- Shared package `manchester_pkg`: state enum (`ST_HUNT`, `ST_LEN`, `ST_PAYLOAD`) and the default `SYNC_WORD` constant (8'hD5).
- Sub-module `byte_fifo`: synchronous FIFO, 9-bit entries {last, data}, `FIFO_DEPTH` parameter, full/empty flags, async active-low reset.
- Top level: bit serializer loop (2 iterations), FSM, counters.

## Test plan
- Single-bit feed of D5, 03, A1, B2, C3 -> `sync_found` once; bytes A1, B2, C3 out; `tlast` only on C3.
- Same frame fed as 2-bit pairs with sync ending on the older bit of a pair -> identical output; leftover bit lands correctly in the length byte.
- Random 0/1/2 bit gaps, preceded by noise bits containing a partial D5 -> exactly one frame decoded; value-3 counts ignored.
- Frame L=5, bits stop after 2 payload bytes for 64 cycles -> `err_timeout` pulse; 2 bytes delivered with no `tlast`; FSM back in HUNT; next frame decodes.
- `tready` = 0, frame L=6, `FIFO_DEPTH` = 4 -> 4 bytes queued; `err_overflow` on the 5th; after `tready` = 1, exactly 4 bytes drain.
- Assert `aresetn` = 0 mid-payload -> outputs 0 immediately; after release, a clean frame decodes with L=1 and `tlast` on byte 1.
